// File: rtl/cnt_yi_pkg.sv
// rtl/cnt_yi_pkg.sv - shared state encoding for the loadable down-counter
package cnt_yi_pkg;

    localparam logic [0:0] CNT_IDLE = 1'b0;
    localparam logic [0:0] CNT_RUN  = 1'b1;

endpackage

// File: rtl/count_down_ld_yi.sv
// rtl/count_down_ld_yi.sv - loadable down-counter with valid/ready load port (optional CNT_DOWN_RELOAD_EN)
module count_down_ld_yi
    import cnt_yi_pkg::*;
#(
    parameter int BITS_OF_END_NUMBER = 10
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          ld_valid,
    output logic                          ld_ready,
    input  logic [BITS_OF_END_NUMBER-1:0] ld_number,
    input  logic                          enable,
    output logic [BITS_OF_END_NUMBER-1:0] total_q,
    output logic                          first,
    output logic                          last,
    output logic                          busy,
    output logic                          done
);

    logic [0:0]                    state_q;
    logic [BITS_OF_END_NUMBER-1:0] cnt_q;
    logic [BITS_OF_END_NUMBER-1:0] load_q;
    logic                          busy_q;
    logic                          done_q;
    logic                          step;
    logic                          at_zero;
    logic                          load_fire;

    // A step only happens while a run is active and the consumer enables it
    always_comb begin
        step    = (state_q == CNT_RUN) && enable;
        at_zero = (cnt_q == '0);
        first   = step && (cnt_q == load_q);
        last    = step && at_zero;
`ifdef CNT_DOWN_RELOAD_EN
        // Accepting on the final step lets the next run start with no bubble
        ld_ready = (state_q == CNT_IDLE) || (step && at_zero);
`else
        ld_ready = (state_q == CNT_IDLE);
`endif
        load_fire = ld_valid && ld_ready;
    end

    // Run control: a load takes priority over finishing so a reload keeps the run going
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= CNT_IDLE;
            cnt_q   <= '0;
            load_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= step && at_zero;
            if (load_fire) begin
                state_q <= CNT_RUN;
                cnt_q   <= ld_number;
                load_q  <= ld_number;
                busy_q  <= 1'b1;
            end else if (step) begin
                if (at_zero) begin
                    state_q <= CNT_IDLE;
                    busy_q  <= 1'b0;
                end else begin
                    cnt_q <= cnt_q - 1'b1;
                end
            end
        end
    end

    assign total_q = cnt_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: tb/tb_count_down_ld_yi.sv
// tb/tb_count_down_ld_yi.sv - directed self-checking bench for count_down_ld_yi
module tb_count_down_ld_yi;

    logic       clk = 1'b0;
    logic       reset;
    logic       ld_valid, ld_ready, enable, first, last, busy, done;
    logic [9:0] ld_number, total_q;
    logic       ld_valid_4, ld_ready_4, enable_4, first_4, last_4, busy_4, done_4;
    logic [3:0] ld_number_4, total_q_4;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    count_down_ld_yi #(.BITS_OF_END_NUMBER(10)) dut (
        .clk(clk), .reset(reset), .ld_valid(ld_valid), .ld_ready(ld_ready),
        .ld_number(ld_number), .enable(enable), .total_q(total_q),
        .first(first), .last(last), .busy(busy), .done(done)
    );

    count_down_ld_yi #(.BITS_OF_END_NUMBER(4)) dut4 (
        .clk(clk), .reset(reset), .ld_valid(ld_valid_4), .ld_ready(ld_ready_4),
        .ld_number(ld_number_4), .enable(enable_4), .total_q(total_q_4),
        .first(first_4), .last(last_4), .busy(busy_4), .done(done_4)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; ld_valid = 1'b0; ld_number = '0; enable = 1'b0;
        ld_valid_4 = 1'b0; ld_number_4 = '0; enable_4 = 1'b0;
        #12;
        if (total_q !== 10'd0) begin $display("FAIL rst_total got %0d exp 0", total_q); miscompares++; end vectors++;
        if (busy !== 1'b0) begin $display("FAIL rst_busy got %b exp 0", busy); miscompares++; end vectors++;
        if (done !== 1'b0) begin $display("FAIL rst_done got %b exp 0", done); miscompares++; end vectors++;
        if ({first, last} !== 2'b00) begin $display("FAIL rst_first_last got %b exp 00", {first, last}); miscompares++; end vectors++;
        cyc();
        reset = 1'b0;
        cyc();
        if (ld_ready !== 1'b1) begin $display("FAIL rst_ld_ready got %b exp 1", ld_ready); miscompares++; end vectors++;
        if (busy !== 1'b0) begin $display("FAIL rst_busy2 got %b exp 0", busy); miscompares++; end vectors++;
    endtask

    task automatic test_basic_run();
        ld_number = 10'd3; ld_valid = 1'b1; enable = 1'b1;
        cyc();
        ld_valid = 1'b0;
        if (ld_ready !== 1'b0) begin $display("FAIL t1_ready_run got %b exp 0", ld_ready); miscompares++; end vectors++;
        if (busy !== 1'b1) begin $display("FAIL t1_busy got %b exp 1", busy); miscompares++; end vectors++;
        for (int k = 3; k >= 0; k--) begin
            if (total_q !== 10'(k)) begin $display("FAIL t1_total got %0d exp %0d", total_q, k); miscompares++; end vectors++;
            if (first !== (k == 3)) begin $display("FAIL t1_first got %b exp %b at %0d", first, (k == 3), k); miscompares++; end vectors++;
            if (last !== (k == 0)) begin $display("FAIL t1_last got %b exp %b at %0d", last, (k == 0), k); miscompares++; end vectors++;
            if (done !== 1'b0) begin $display("FAIL t1_done_early got %b exp 0 at %0d", done, k); miscompares++; end vectors++;
            cyc();
        end
        if (done !== 1'b1) begin $display("FAIL t1_done got %b exp 1", done); miscompares++; end vectors++;
        if (busy !== 1'b0) begin $display("FAIL t1_busy_end got %b exp 0", busy); miscompares++; end vectors++;
        if (ld_ready !== 1'b1) begin $display("FAIL t1_ready_end got %b exp 1", ld_ready); miscompares++; end vectors++;
        cyc();
        if (done !== 1'b0) begin $display("FAIL t1_done_pulse got %b exp 0", done); miscompares++; end vectors++;
    endtask

    task automatic test_load_zero();
        ld_number = 10'd0; ld_valid = 1'b1; enable = 1'b1;
        cyc();
        ld_valid = 1'b0;
        if ({first, last} !== 2'b11) begin $display("FAIL t2_first_last got %b exp 11", {first, last}); miscompares++; end vectors++;
        if (busy !== 1'b1) begin $display("FAIL t2_busy got %b exp 1", busy); miscompares++; end vectors++;
        cyc();
        if (done !== 1'b1) begin $display("FAIL t2_done got %b exp 1", done); miscompares++; end vectors++;
        if (busy !== 1'b0) begin $display("FAIL t2_busy_end got %b exp 0", busy); miscompares++; end vectors++;
        cyc();
        if (done !== 1'b0) begin $display("FAIL t2_done_pulse got %b exp 0", done); miscompares++; end vectors++;
    endtask

    task automatic test_enable_stall();
        int exp_cnt = 5;
        int steps = 0;
        bit fin = 0;
        ld_number = 10'd5; ld_valid = 1'b1; enable = 1'b0;
        cyc();
        ld_valid = 1'b0;
        for (int c = 0; c < 40 && !fin; c++) begin
            enable = (c % 3 == 0);
            #1;
            if (total_q !== 10'(exp_cnt)) begin $display("FAIL t3_total got %0d exp %0d", total_q, exp_cnt); miscompares++; end vectors++;
            if (first !== (enable && exp_cnt == 5)) begin $display("FAIL t3_first got %b exp %b", first, (enable && exp_cnt == 5)); miscompares++; end vectors++;
            if (last !== (enable && exp_cnt == 0)) begin $display("FAIL t3_last got %b exp %b", last, (enable && exp_cnt == 0)); miscompares++; end vectors++;
            if (enable) begin
                steps++;
                if (exp_cnt == 0) fin = 1; else exp_cnt--;
            end
            cyc();
        end
        if (!fin) begin $display("FAIL t3_timeout got 0 exp 1"); miscompares++; end vectors++;
        if (steps !== 6) begin $display("FAIL t3_steps got %0d exp 6", steps); miscompares++; end vectors++;
        if (done !== 1'b1) begin $display("FAIL t3_done got %b exp 1", done); miscompares++; end vectors++;
        enable = 1'b0;
        cyc();
    endtask

    task automatic test_load_during_run();
        ld_number = 10'd3; ld_valid = 1'b1; enable = 1'b1;
        cyc();
        ld_number = 10'd7;
        if (ld_ready !== 1'b0) begin $display("FAIL t4_ready_run got %b exp 0", ld_ready); miscompares++; end vectors++;
        cyc();
        if (total_q !== 10'd2) begin $display("FAIL t4_no_accept got %0d exp 2", total_q); miscompares++; end vectors++;
        cyc();
        cyc();
        if (last !== 1'b1) begin $display("FAIL t4_last got %b exp 1", last); miscompares++; end vectors++;
`ifdef CNT_DOWN_RELOAD_EN
        if (ld_ready !== 1'b1) begin $display("FAIL t4_ready_last got %b exp 1", ld_ready); miscompares++; end vectors++;
        cyc();
        if (done !== 1'b1) begin $display("FAIL t4_done got %b exp 1", done); miscompares++; end vectors++;
`else
        if (ld_ready !== 1'b0) begin $display("FAIL t4_ready_last got %b exp 0", ld_ready); miscompares++; end vectors++;
        cyc();
        if (total_q !== 10'd0) begin $display("FAIL t4_idle_total got %0d exp 0", total_q); miscompares++; end vectors++;
        if (done !== 1'b1) begin $display("FAIL t4_done got %b exp 1", done); miscompares++; end vectors++;
        if (ld_ready !== 1'b1) begin $display("FAIL t4_ready_idle got %b exp 1", ld_ready); miscompares++; end vectors++;
        cyc();
`endif
        ld_valid = 1'b0;
        if (total_q !== 10'd7) begin $display("FAIL t4_reload_total got %0d exp 7", total_q); miscompares++; end vectors++;
        if (first !== 1'b1) begin $display("FAIL t4_reload_first got %b exp 1", first); miscompares++; end vectors++;
        if (busy !== 1'b1) begin $display("FAIL t4_reload_busy got %b exp 1", busy); miscompares++; end vectors++;
        for (int k = 7; k >= 0; k--) begin
            if (total_q !== 10'(k)) begin $display("FAIL t4_total got %0d exp %0d", total_q, k); miscompares++; end vectors++;
            cyc();
        end
        if (done !== 1'b1) begin $display("FAIL t4_done2 got %b exp 1", done); miscompares++; end vectors++;
        enable = 1'b0;
        cyc();
    endtask

    task automatic test_reset_mid_run();
        ld_number = 10'd3; ld_valid = 1'b1; enable = 1'b1;
        cyc();
        ld_valid = 1'b0;
        cyc();
        if (total_q !== 10'd2) begin $display("FAIL t5_pre_total got %0d exp 2", total_q); miscompares++; end vectors++;
        reset = 1'b1;
        #1;
        if (busy !== 1'b0) begin $display("FAIL t5_busy got %b exp 0", busy); miscompares++; end vectors++;
        if (total_q !== 10'd0) begin $display("FAIL t5_total got %0d exp 0", total_q); miscompares++; end vectors++;
        if (ld_ready !== 1'b1) begin $display("FAIL t5_ready got %b exp 1", ld_ready); miscompares++; end vectors++;
        cyc();
        reset = 1'b0;
        cyc();
        if (done !== 1'b0) begin $display("FAIL t5_no_done got %b exp 0", done); miscompares++; end vectors++;
        ld_number = 10'd1; ld_valid = 1'b1;
        cyc();
        ld_valid = 1'b0;
        if (total_q !== 10'd1 || first !== 1'b1) begin $display("FAIL t5_new_step0 got %0d/%b exp 1/1", total_q, first); miscompares++; end vectors++;
        cyc();
        if (total_q !== 10'd0 || last !== 1'b1) begin $display("FAIL t5_new_step1 got %0d/%b exp 0/1", total_q, last); miscompares++; end vectors++;
        cyc();
        if (done !== 1'b1 || busy !== 1'b0) begin $display("FAIL t5_new_done got %b/%b exp 1/0", done, busy); miscompares++; end vectors++;
        enable = 1'b0;
        cyc();
    endtask

    task automatic test_full_range_w4();
        int lasts = 0;
        int dones = 0;
        ld_number_4 = 4'd15; ld_valid_4 = 1'b1; enable_4 = 1'b1;
        cyc();
        ld_valid_4 = 1'b0;
        for (int k = 15; k >= 0; k--) begin
            if (total_q_4 !== 4'(k)) begin $display("FAIL t6_total got %0d exp %0d", total_q_4, k); miscompares++; end vectors++;
            lasts += int'(last_4);
            dones += int'(done_4);
            cyc();
        end
        if (total_q_4 !== 4'd0) begin $display("FAIL t6_no_wrap got %0d exp 0", total_q_4); miscompares++; end vectors++;
        for (int c = 0; c < 2; c++) begin
            lasts += int'(last_4);
            dones += int'(done_4);
            cyc();
        end
        if (lasts !== 1) begin $display("FAIL t6_last_count got %0d exp 1", lasts); miscompares++; end vectors++;
        if (dones !== 1) begin $display("FAIL t6_done_count got %0d exp 1", dones); miscompares++; end vectors++;
        if (busy_4 !== 1'b0) begin $display("FAIL t6_busy got %b exp 0", busy_4); miscompares++; end vectors++;
        enable_4 = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic_run();
        test_load_zero();
        test_enable_stall();
        test_load_during_run();
        test_reset_mid_run();
        test_full_range_w4();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
